pipe_hazard_ctrl: RTL and testbench

Pipeline hazard and stall controller for the 5-stage core. It produces the PC counter enable and the IF/ID and ID/EX enable/flush controls, and freezes the pipeline while the data memory is busy. It also holds a branch/jump redirect that arrives during a freeze and replays it afterwards, and generates EX operand-forwarding selects. It sits beside the IF/ID, ID/EX, EX/MEM and MEM/WB registers and drives their enable/flush pins.

---
 rtl/pipe_hazard_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard/stall controller for the 5-stage core.
// Drives PC enable, IF/ID and ID/EX enable/flush, and the shared enable of the
// later pipeline registers. It freezes everything while the data memory is busy.
// A redirect that arrives during a freeze is held and replayed on unfreeze.
// It also produces the EX operand-forwarding selects.
//
// Optional feature macro: HAZARD_FWD_EN
//   defined   -> forwarding selects are live; only load-use hazards stall.
//   undefined -> forwarding tied to 00; any in-flight writer match stalls.
//
// Ports:
//   CLK, RST                       clock, synchronous active-high reset
//   IFIDrs1/2, IFIDuse1/2          ID-stage source registers and use flags
//   IDEXrd/RegWrite/DmemREB        EX-stage writer (DmemREB = 0 marks a load)
//   EXMEMrd/RegWrite/DmemAccess    MEM-stage writer and memory-access flag
//   MEMWBrd/RegWrite               WB-stage writer
//   PCsel, DmemReady               EX redirect, memory completion
//   CNTEN, IFIDEN, IFIDFLUSH       IF-side controls (combinational)
//   IDEXFLUSH, PIPEEN, PCselOut    ID/EX bubble, back-end enable, redirect
//   ForwardA/B                     00 regfile, 01 EX/MEM, 10 MEM/WB
//   StallCount                     saturating count of CNTEN = 0 cycles
//   MemErr                         sticky memory timeout flag
module pipe_hazard_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 255,
   parameter int unsigned STALLCNT_W  = 16
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [4:0]            IFIDrs1,
   input  logic [4:0]            IFIDrs2,
   input  logic                  IFIDuse1,
   input  logic                  IFIDuse2,
   input  logic [4:0]            IDEXrd,
   input  logic                  IDEXRegWrite,
   input  logic                  IDEXDmemREB,
   input  logic [4:0]            EXMEMrd,
   input  logic                  EXMEMRegWrite,
   input  logic                  EXMEMDmemAccess,
   input  logic [4:0]            MEMWBrd,
   input  logic                  MEMWBRegWrite,
   input  logic                  PCsel,
   input  logic                  DmemReady,
   output logic                  CNTEN,
   output logic                  IFIDEN,
   output logic                  IFIDFLUSH,
   output logic                  IDEXFLUSH,
   output logic                  PIPEEN,
   output logic                  PCselOut,
   output logic [1:0]            ForwardA,
   output logic [1:0]            ForwardB,
   output logic [STALLCNT_W-1:0] StallCount,
   output logic                  MemErr
);
   localparam int unsigned REG_W  = 5;
   localparam int unsigned WAIT_W = 16;

   typedef enum logic [1:0] {ST_RUN, ST_MEMWAIT, ST_ERR} state_e;

   state_e                state_q, state_d;
   logic [WAIT_W-1:0]     wait_cnt_q, wait_cnt_d;
   logic                  pend_q, pend_d;
   logic [STALLCNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic                  mem_err_q, mem_err_d;
   logic                  rst_tail_q, rst_tail_d;
   logic                  hit_idex, hazard_stall, mem_busy, in_reset;

   function automatic logic rd_hit(input logic we, input logic [REG_W-1:0] rd,
                                   input logic [REG_W-1:0] rs);
      return we && (rd != '0) && (rd == rs);
   endfunction

   // Reset outputs are shown during RST and for one cycle after it
   assign in_reset = RST || rst_tail_q;
   assign mem_busy = EXMEMDmemAccess && !DmemReady;
   assign hit_idex = (IFIDuse1 && rd_hit(IDEXRegWrite, IDEXrd, IFIDrs1)) ||
                     (IFIDuse2 && rd_hit(IDEXRegWrite, IDEXrd, IFIDrs2));

`ifdef HAZARD_FWD_EN
   // Only a load in EX cannot be forwarded in time
   assign hazard_stall = hit_idex && !IDEXDmemREB;

   // EX/MEM is the younger result, so it wins over MEM/WB
   always_comb begin
      ForwardA = 2'b00;
      ForwardB = 2'b00;
      if (!in_reset) begin
         if (rd_hit(EXMEMRegWrite, EXMEMrd, IFIDrs1))      ForwardA = 2'b01;
         else if (rd_hit(MEMWBRegWrite, MEMWBrd, IFIDrs1)) ForwardA = 2'b10;
         if (rd_hit(EXMEMRegWrite, EXMEMrd, IFIDrs2))      ForwardB = 2'b01;
         else if (rd_hit(MEMWBRegWrite, MEMWBrd, IFIDrs2)) ForwardB = 2'b10;
      end
   end
`else
   logic hit_exmem, hit_memwb, unused_reb;

   // Without forwarding, wait until no in-flight writer matches
   assign hit_exmem = (IFIDuse1 && rd_hit(EXMEMRegWrite, EXMEMrd, IFIDrs1)) ||
                      (IFIDuse2 && rd_hit(EXMEMRegWrite, EXMEMrd, IFIDrs2));
   assign hit_memwb = (IFIDuse1 && rd_hit(MEMWBRegWrite, MEMWBrd, IFIDrs1)) ||
                      (IFIDuse2 && rd_hit(MEMWBRegWrite, MEMWBrd, IFIDrs2));
   assign hazard_stall = hit_idex || hit_exmem || hit_memwb;
   assign unused_reb   = IDEXDmemREB;
   assign ForwardA     = 2'b00;
   assign ForwardB     = 2'b00;
`endif

   // Next state and combinational pipeline controls
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      pend_d     = pend_q;
      mem_err_d  = mem_err_q;
      rst_tail_d = RST;
      CNTEN      = 1'b1;
      IFIDEN     = 1'b1;
      PIPEEN     = 1'b1;
      IFIDFLUSH  = 1'b0;
      IDEXFLUSH  = 1'b0;
      PCselOut   = 1'b0;

      if (in_reset) begin
         CNTEN     = 1'b0;
         IFIDEN    = 1'b0;
         PIPEEN    = 1'b0;
         IFIDFLUSH = 1'b1;
         IDEXFLUSH = 1'b1;
      end else begin
         unique case (state_q)
            ST_RUN: begin
               if (mem_busy) begin
                  CNTEN      = 1'b0;
                  IFIDEN     = 1'b0;
                  PIPEEN     = 1'b0;
                  pend_d     = pend_q | PCsel;
                  wait_cnt_d = '0;
                  state_d    = ST_MEMWAIT;
               end else if (PCsel) begin
                  PCselOut  = 1'b1;
                  IFIDFLUSH = 1'b1;
                  IDEXFLUSH = 1'b1;
               end else if (hazard_stall) begin
                  CNTEN     = 1'b0;
                  IFIDEN    = 1'b0;
                  IDEXFLUSH = 1'b1;
               end
            end
            ST_MEMWAIT: begin
               if (DmemReady) begin
                  // Unfreeze now; the held redirect replaces the live PCsel
                  state_d = ST_RUN;
                  pend_d  = 1'b0;
                  if (pend_q) begin
                     PCselOut  = 1'b1;
                     IFIDFLUSH = 1'b1;
                     IDEXFLUSH = 1'b1;
                  end else if (hazard_stall) begin
                     CNTEN     = 1'b0;
                     IFIDEN    = 1'b0;
                     IDEXFLUSH = 1'b1;
                  end
               end else begin
                  CNTEN      = 1'b0;
                  IFIDEN     = 1'b0;
                  PIPEEN     = 1'b0;
                  wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                  if ((32'(wait_cnt_q) + 32'd1) >= MEM_TIMEOUT) begin
                     mem_err_d = 1'b1;
                     state_d   = ST_ERR;
                  end
               end
            end
            ST_ERR: begin
               CNTEN  = 1'b0;
               IFIDEN = 1'b0;
               PIPEEN = 1'b0;
            end
            default: state_d = ST_RUN;
         endcase
      end

      stall_cnt_d = stall_cnt_q;
      if (!in_reset && !CNTEN && (stall_cnt_q != '1))
         stall_cnt_d = stall_cnt_q + STALLCNT_W'(1);
   end

   always_ff @(posedge CLK) begin
      rst_tail_q <= rst_tail_d;
      if (RST) begin
         state_q     <= ST_RUN;
         wait_cnt_q  <= '0;
         pend_q      <= 1'b0;
         stall_cnt_q <= '0;
         mem_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         pend_q      <= pend_d;
         stall_cnt_q <= stall_cnt_d;
         mem_err_q   <= mem_err_d;
      end
   end

   assign StallCount = stall_cnt_q;
   assign MemErr     = mem_err_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl: directed scenarios followed by random
// stimulus, all checked cycle by cycle against a behavioural model.
module tb_pipe_hazard_ctrl;
   localparam int unsigned TO   = 4;
   localparam int unsigned SW   = 4;
   localparam int unsigned SMAX = (1 << SW) - 1;

   logic          CLK = 1'b0;
   logic          RST;
   logic [4:0]    IFIDrs1, IFIDrs2, IDEXrd, EXMEMrd, MEMWBrd;
   logic          IFIDuse1, IFIDuse2, IDEXRegWrite, IDEXDmemREB;
   logic          EXMEMRegWrite, EXMEMDmemAccess, MEMWBRegWrite, PCsel, DmemReady;
   logic          CNTEN, IFIDEN, IFIDFLUSH, IDEXFLUSH, PIPEEN, PCselOut, MemErr;
   logic [1:0]    ForwardA, ForwardB;
   logic [SW-1:0] StallCount;

   pipe_hazard_ctrl #(.MEM_TIMEOUT(TO), .STALLCNT_W(SW)) dut (
      .CLK(CLK), .RST(RST),
      .IFIDrs1(IFIDrs1), .IFIDrs2(IFIDrs2), .IFIDuse1(IFIDuse1), .IFIDuse2(IFIDuse2),
      .IDEXrd(IDEXrd), .IDEXRegWrite(IDEXRegWrite), .IDEXDmemREB(IDEXDmemREB),
      .EXMEMrd(EXMEMrd), .EXMEMRegWrite(EXMEMRegWrite), .EXMEMDmemAccess(EXMEMDmemAccess),
      .MEMWBrd(MEMWBrd), .MEMWBRegWrite(MEMWBRegWrite),
      .PCsel(PCsel), .DmemReady(DmemReady),
      .CNTEN(CNTEN), .IFIDEN(IFIDEN), .IFIDFLUSH(IFIDFLUSH), .IDEXFLUSH(IDEXFLUSH),
      .PIPEEN(PIPEEN), .PCselOut(PCselOut), .ForwardA(ForwardA), .ForwardB(ForwardB),
      .StallCount(StallCount), .MemErr(MemErr)
   );

   always #5 CLK = ~CLK;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
      n_cmp++;
      if (obs != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // Behavioural model: freeze bookkeeping as plain flags and integers
   bit   m_known, m_tail, m_wait, m_err, m_pend;
   int   m_wait_n, m_stalls;
   bit   e_cnten, e_ifiden, e_pipeen, e_iff, e_idf, e_pcs;
   logic [1:0] e_fa, e_fb;

   function automatic bit reads(input bit we, input logic [4:0] rd);
      return we && rd != 5'd0 &&
             ((IFIDuse1 && rd == IFIDrs1) || (IFIDuse2 && rd == IFIDrs2));
   endfunction

   function automatic logic [1:0] fwd_for(input logic [4:0] rs);
      if (EXMEMRegWrite && EXMEMrd != 5'd0 && EXMEMrd == rs) return 2'b01;
      if (MEMWBRegWrite && MEMWBrd != 5'd0 && MEMWBrd == rs) return 2'b10;
      return 2'b00;
   endfunction

   function automatic bit must_stall();
`ifdef HAZARD_FWD_EN
      return reads(IDEXRegWrite && !IDEXDmemREB, IDEXrd);
`else
      return reads(IDEXRegWrite, IDEXrd) || reads(EXMEMRegWrite, EXMEMrd) ||
             reads(MEMWBRegWrite, MEMWBrd);
`endif
   endfunction

   task automatic set_exp(input bit c, input bit i, input bit p, input bit f1,
                          input bit f2, input bit r);
      e_cnten = c; e_ifiden = i; e_pipeen = p; e_iff = f1; e_idf = f2; e_pcs = r;
   endtask

   task automatic model_eval();
      bit redirect;
      set_exp(1, 1, 1, 0, 0, 0);
      if (RST || m_tail)                  set_exp(0, 0, 0, 1, 1, 0);
      else if (m_err)                     set_exp(0, 0, 0, 0, 0, 0);
      else if (m_wait && !DmemReady)      set_exp(0, 0, 0, 0, 0, 0);
      else if (!m_wait && EXMEMDmemAccess && !DmemReady) set_exp(0, 0, 0, 0, 0, 0);
      else begin
         redirect = m_wait ? m_pend : PCsel;
         if (redirect)          set_exp(1, 1, 1, 1, 1, 1);
         else if (must_stall()) set_exp(0, 0, 1, 0, 1, 0);
      end
`ifdef HAZARD_FWD_EN
      e_fa = (RST || m_tail) ? 2'b00 : fwd_for(IFIDrs1);
      e_fb = (RST || m_tail) ? 2'b00 : fwd_for(IFIDrs2);
`else
      e_fa = 2'b00;
      e_fb = 2'b00;
`endif
   endtask

   task automatic model_commit();
      if (RST) begin
         m_known = 1; m_tail = 1; m_wait = 0; m_err = 0; m_pend = 0; m_stalls = 0;
         m_wait_n = 0;
      end else begin
         if (!m_tail && !e_cnten && m_stalls < int'(SMAX)) m_stalls++;
         if (m_tail) m_tail = 0;
         else if (m_err) ;
         else if (m_wait) begin
            if (DmemReady) begin
               m_wait = 0; m_pend = 0;
            end else begin
               m_wait_n++;
               if (m_wait_n >= int'(TO)) begin m_err = 1; m_wait = 0; end
            end
         end else if (EXMEMDmemAccess && !DmemReady) begin
            m_wait = 1; m_wait_n = 0; m_pend = PCsel;
         end
      end
   endtask

   task automatic eval_cycle();
      #1;
      model_eval();
      check_eq("CNTEN", CNTEN, e_cnten);
      check_eq("IFIDEN", IFIDEN, e_ifiden);
      check_eq("PIPEEN", PIPEEN, e_pipeen);
      check_eq("IFIDFLUSH", IFIDFLUSH, e_iff);
      check_eq("IDEXFLUSH", IDEXFLUSH, e_idf);
      check_eq("PCselOut", PCselOut, e_pcs);
      check_eq("ForwardA", ForwardA, e_fa);
      check_eq("ForwardB", ForwardB, e_fb);
      if (m_known) begin
         check_eq("StallCount", StallCount, m_stalls);
         check_eq("MemErr", MemErr, m_err);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      model_commit();
      @(negedge CLK);
   endtask

   task automatic idle();
      IFIDrs1 = 0; IFIDrs2 = 0; IFIDuse1 = 0; IFIDuse2 = 0;
      IDEXrd = 0; IDEXRegWrite = 0; IDEXDmemREB = 1;
      EXMEMrd = 0; EXMEMRegWrite = 0; EXMEMDmemAccess = 0;
      MEMWBrd = 0; MEMWBRegWrite = 0; PCsel = 0; DmemReady = 0;
   endtask

   task automatic load_use();
      IDEXrd = 5; IDEXDmemREB = 0; IDEXRegWrite = 1; IFIDrs1 = 5; IFIDuse1 = 1;
   endtask

   task automatic rand_inputs();
      RST             = ($urandom_range(0, 39) == 0);
      IFIDrs1         = 5'($urandom_range(0, 7));
      IFIDrs2         = 5'($urandom_range(0, 7));
      IFIDuse1        = 1'($urandom_range(0, 1));
      IFIDuse2        = 1'($urandom_range(0, 1));
      IDEXrd          = 5'($urandom_range(0, 7));
      IDEXRegWrite    = 1'($urandom_range(0, 1));
      IDEXDmemREB     = 1'($urandom_range(0, 1));
      EXMEMrd         = 5'($urandom_range(0, 7));
      EXMEMRegWrite   = 1'($urandom_range(0, 1));
      EXMEMDmemAccess = 1'($urandom_range(0, 1));
      MEMWBrd         = 5'($urandom_range(0, 7));
      MEMWBRegWrite   = 1'($urandom_range(0, 1));
      PCsel           = ($urandom_range(0, 5) == 0);
      DmemReady       = ($urandom_range(0, 2) != 0);
   endtask

   initial begin
      int pcs_seen, nf_stalls;
      idle();
      RST = 1;
      @(negedge CLK);
      // Reset held two cycles, then one more cycle of reset outputs
      repeat (2) begin eval_cycle(); tick(); end
      RST = 0;
      eval_cycle(); check_eq("rel1_cnten", CNTEN, 0); tick();
      eval_cycle(); check_eq("rel2_cnten", CNTEN, 1);
      check_eq("rel2_stall", StallCount, 0); tick();

      // Load-use: one bubble, then the result comes from MEM/WB
      load_use();
      eval_cycle(); check_eq("lu_cnten", CNTEN, 0); check_eq("lu_idexflush", IDEXFLUSH, 1);
      tick();
      idle(); MEMWBrd = 5; MEMWBRegWrite = 1; IFIDrs1 = 5;
      eval_cycle(); check_eq("lu_stallcnt", StallCount, 1); check_eq("lu_cnten2", CNTEN, 1);
`ifdef HAZARD_FWD_EN
      check_eq("lu_fwda", ForwardA, 2);
`else
      check_eq("lu_fwda", ForwardA, 0);
`endif
      tick();

      // Taken branch, then branch together with a load-use hazard
      idle(); PCsel = 1;
      eval_cycle();
      check_eq("br_pcsel", PCselOut, 1); check_eq("br_iff", IFIDFLUSH, 1);
      check_eq("br_idf", IDEXFLUSH, 1); check_eq("br_cnten", CNTEN, 1);
      check_eq("br_stall", StallCount, 1);
      tick();
      load_use(); PCsel = 1;
      eval_cycle(); check_eq("brhz_cnten", CNTEN, 1); check_eq("brhz_idf", IDEXFLUSH, 1);
      tick();

      // Memory wait with a redirect in the first frozen cycle
      idle(); EXMEMDmemAccess = 1; PCsel = 1; pcs_seen = 0;
      for (int k = 0; k < 3; k++) begin
         PCsel = (k != 1);
         eval_cycle(); check_eq("mw_pipeen", PIPEEN, 0); pcs_seen += int'(PCselOut); tick();
      end
      PCsel = 0; DmemReady = 1;
      eval_cycle(); check_eq("mw_pipeen_on", PIPEEN, 1); check_eq("mw_stall", StallCount, 4);
      pcs_seen += int'(PCselOut); tick();
      idle();
      eval_cycle(); pcs_seen += int'(PCselOut); tick();
      check_eq("mw_redirects", pcs_seen, 1);

      // Timeout, frozen error state, saturating stall counter
      idle(); EXMEMDmemAccess = 1;
      for (int k = 0; k < 5; k++) begin
         eval_cycle(); check_eq("to_memerr0", MemErr, 0); tick();
      end
      eval_cycle(); check_eq("to_memerr1", MemErr, 1); check_eq("to_pipeen", PIPEEN, 0);
      tick();
      idle();
      repeat (14) begin eval_cycle(); tick(); end
      eval_cycle(); check_eq("sat_stall", StallCount, SMAX); check_eq("err_iff", IFIDFLUSH, 0);
      tick();
      RST = 1;
      repeat (2) begin eval_cycle(); tick(); end
      check_eq("rst_memerr", MemErr, 0);
      RST = 0;
      eval_cycle(); tick();

      // ALU writer of x7 followed by a reader of x7 through the pipe
      nf_stalls = 0;
      idle(); IDEXrd = 7; IDEXRegWrite = 1; IFIDrs1 = 7; IFIDuse1 = 1;
      eval_cycle(); nf_stalls += int'(!CNTEN); tick();
      idle(); EXMEMrd = 7; EXMEMRegWrite = 1; IFIDrs1 = 7; IFIDuse1 = 1;
      eval_cycle(); nf_stalls += int'(!CNTEN); tick();
      idle(); MEMWBrd = 7; MEMWBRegWrite = 1; IFIDrs1 = 7; IFIDuse1 = 1;
      eval_cycle(); nf_stalls += int'(!CNTEN); tick();
      idle(); IFIDrs1 = 7; IFIDuse1 = 1;
      eval_cycle(); nf_stalls += int'(!CNTEN); tick();
`ifdef HAZARD_FWD_EN
      check_eq("nf_stalls", nf_stalls, 0);
`else
      check_eq("nf_stalls", nf_stalls, 3);
`endif

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         rand_inputs();
         eval_cycle();
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
